// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and helpers for the neuron_mac block.
//   state_t   - control FSM states (IDLE, MAC, BIAS, OUT)
//   acc_width - accumulator width that holds N_IN full-width products
//               plus bias without overflow
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic int acc_width(input int n_in, input int dw);
    return 2 * dw + $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/neuron_act.sv
// neuron_act: combinational activation path.
//   Takes the biased accumulator sum, arithmetic-shifts it right by FRAC
//   (rounds toward minus infinity), applies ReLU and then either clamps
//   (NEURON_SAT_EN defined) or wraps to DW-1 bits with the MSB cleared.
// Ports:
//   sum  in   ACCW  signed accumulator + scaled bias
//   act  out  DW    activation, MSB always 0
// Build option: NEURON_SAT_EN enables saturation instead of wrap.
module neuron_act #(
  parameter int ACCW = 35,
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic signed [ACCW-1:0] sum,
  output logic        [DW-1:0]   act
);

  logic signed [ACCW-1:0] shifted;

  assign shifted = sum >>> FRAC;

`ifdef NEURON_SAT_EN
  localparam logic signed [ACCW-1:0] MAX_POS =
    {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};

  always_comb begin
    // NOTE: the default assignment first guarantees every path drives act,
    // so no latch is inferred.
    act = '0;
    if (!shifted[ACCW-1]) begin
      if (shifted > MAX_POS) act = MAX_POS[DW-1:0];
      else                   act = shifted[DW-1:0];
    end
  end
`else
  // Upper bits are intentionally dropped by the wrap behaviour.
  logic unused_hi;
  assign unused_hi = ^shifted[ACCW-2:DW-1];

  always_comb begin
    act = '0;
    if (!shifted[ACCW-1]) act = {1'b0, shifted[DW-2:0]};
  end
`endif

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: single fixed-point neuron, sequential multiply-accumulate.
//   Accepts an N_IN-element vector, accumulates in[i]*w[i] one term per
//   cycle, adds the bias, and presents the ReLU activation until accepted.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input vector handshake (ready only in IDLE)
//   in_data             packed signed inputs, element i at [i*DW +: DW]
//   w_we/w_addr/w_data  coefficient write (addr N_IN = bias), IDLE only
//   out_valid/out_ready result handshake
//   out_data            activation, held outside OUT
//   busy                high whenever not IDLE
// Build option: NEURON_SAT_EN (see neuron_act) selects clamp vs wrap.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N_IN = 5,
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DW-1:0]       in_data,
  input  logic                     w_we,
  input  logic [$clog2(N_IN+1)-1:0] w_addr,
  input  logic [DW-1:0]            w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic                     busy
);

  localparam int AW   = $clog2(N_IN + 1);
  localparam int ACCW = acc_width(N_IN, DW);

  state_t                 state, state_nxt;
  logic [N_IN*DW-1:0]     x_q;
  logic signed [DW-1:0]   w_q [N_IN];
  logic signed [DW-1:0]   bias_q;
  logic signed [ACCW-1:0] acc_q;
  logic [AW-1:0]          idx_q;

  logic signed [DW-1:0]   x_sel, w_sel;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] sum;
  logic        [DW-1:0]   act;

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MAC;
      end
      MAC:  if (idx_q == AW'(N_IN - 1)) state_nxt = BIAS;
      BIAS: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the current term by comparison so the index width never has to
  // match the array size exactly.
  always_comb begin
    x_sel = '0;
    w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == AW'(i)) begin
        x_sel = x_q[i*DW +: DW];
        w_sel = w_q[i];
      end
    end
  end

  assign prod = (2*DW)'(x_sel) * (2*DW)'(w_sel);
  assign sum  = acc_q + (ACCW'(bias_q) <<< FRAC);

  neuron_act #(
    .ACCW(ACCW),
    .DW  (DW),
    .FRAC(FRAC)
  ) u_act (
    .sum(sum),
    .act(act)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      out_data <= '0;
      bias_q   <= '0;
      // NOTE: the coefficient array is cleared by reset, so it has to stay
      // in flops; a reset loop like this cannot map onto a RAM macro.
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
    end else begin
      state <= state_nxt;

      // Coefficient writes only land while idle; that edge is also the one
      // that captures a same-cycle vector, which then sees the new value.
      if (state == IDLE && w_we) begin
        if (w_addr == AW'(N_IN)) bias_q <= w_data;
        for (int i = 0; i < N_IN; i++) begin
          if (w_addr == AW'(i)) w_q[i] <= w_data;
        end
      end

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= in_data;
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACCW'(prod);
          idx_q <= idx_q + AW'(1);
        end
        BIAS:    out_data <= act;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench for neuron_mac (N_IN=5, DW=16, FRAC=8).
// Build option: NEURON_SAT_EN switches the reference model to clamping.
module tb_neuron_mac;

  localparam int N_IN = 5;
  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int AW   = $clog2(N_IN + 1);

`ifdef NEURON_SAT_EN
  localparam logic [DW-1:0] SAT_EXP  = 16'h7FFF;
  localparam logic [DW-1:0] W0_EXP   = 16'h7FFF;
  localparam logic [DW-1:0] SAME_EXP = 16'h7FFF;
`else
  localparam logic [DW-1:0] SAT_EXP  = 16'h7B00;
  localparam logic [DW-1:0] W0_EXP   = 16'h03FF;
  localparam logic [DW-1:0] SAME_EXP = 16'h04FF;
`endif

  logic               clk       = 1'b0;
  logic               reset     = 1'b1;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic [N_IN*DW-1:0] in_data   = '0;
  logic               w_we      = 1'b0;
  logic [AW-1:0]      w_addr    = '0;
  logic [DW-1:0]      w_data    = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [DW-1:0]      out_data;
  logic               busy;

  always #5 clk = ~clk;

  neuron_mac #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shadow coefficients, updated only for writes the bench expects to land.
  logic signed [DW-1:0] sw [N_IN];
  logic signed [DW-1:0] sbias;

  function automatic logic [DW-1:0] model(input logic [N_IN*DW-1:0] v);
    longint acc  = 0;
    longint sh;
    longint maxv = (longint'(1) << (DW - 1)) - 1;
    logic signed [DW-1:0] a;
    for (int i = 0; i < N_IN; i++) begin
      a = v[i*DW +: DW];
      acc += longint'(a) * longint'(sw[i]);
    end
    acc += longint'(sbias) * (longint'(1) << FRAC);
    sh = acc >>> FRAC;
    if (sh < 0) return '0;
`ifdef NEURON_SAT_EN
    if (sh > maxv) sh = maxv;
`else
    sh = sh % (maxv + 1);
`endif
    return DW'(sh);
  endfunction

  function automatic logic [N_IN*DW-1:0] fill(input logic [DW-1:0] x);
    return {N_IN{x}};
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } exp_t;

  exp_t sbq[$];
  exp_t pe;
  int   cyc     = 0;
  int   n_out   = 0;
  int   last_t  = -1;
  int   prev_t  = -1;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push on input transfer, pop on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
    end else begin
      if (in_valid && in_ready) begin
        sbq.push_back('{model(in_data), cyc});
        prev_t = last_t;
        last_t = cyc;
      end
      if (out_valid && !prev_ov) begin
        if (sbq.size() == 0) check("spurious_out_valid", out_valid, 0);
        else                 check("latency", cyc - sbq[0].t, N_IN + 2);
      end
      if (out_valid && out_ready && sbq.size() > 0) begin
        pe = sbq.pop_front();
        check("out_data", out_data, pe.data);
        n_out++;
      end
    end
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < N_IN; i++) sw[i] = '0;
    sbias = '0;
  endtask

  task automatic write_coef(input int addr, input logic [DW-1:0] d, input bit accept);
    w_we   = 1'b1;
    w_addr = AW'(addr);
    w_data = d;
    if (accept) begin
      if (addr == N_IN)    sbias   = d;
      else if (addr < N_IN) sw[addr] = d;
    end
    tick();
    w_we = 1'b0;
  endtask

  task automatic send_vec(input logic [N_IN*DW-1:0] v, input bit we,
                          input int addr, input logic [DW-1:0] d);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    if (we) begin
      w_we   = 1'b1;
      w_addr = AW'(addr);
      w_data = d;
      if (addr == N_IN)    sbias   = d;
      else if (addr < N_IN) sw[addr] = d;
    end
    tick();
    in_valid = 1'b0;
    w_we     = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (n_out < target && n < 100) begin
      tick();
      n++;
    end
    check("result_count", n_out, target);
  endtask

  logic [DW-1:0] hold;

  initial begin
    clear_shadow();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);

    // Basic vector.
    for (int i = 0; i < N_IN; i++) write_coef(i, 16'h0100, 1);
    write_coef(N_IN, 16'h0000, 1);
    send_vec(fill(16'h0100), 0, 0, '0);
    check("busy_in_mac", busy, 1);
    wait_out(1);
    check("basic_value", out_data, 16'h0500);
    check("out_valid_low_idle", out_valid, 0);

    // Back-to-back vectors with out_ready high.
    send_vec(fill(16'h0200), 0, 0, '0);
    send_vec(fill(16'hFF00), 0, 0, '0);
    wait_out(3);
    check("throughput", last_t - prev_t, N_IN + 3);

    // ReLU clips a negative result.
    write_coef(N_IN, 16'hF000, 1);
    send_vec(fill(16'h0100), 0, 0, '0);
    wait_out(4);
    check("relu_zero", out_data, 16'h0000);

    // Large positive result: clamp or wrap.
    for (int i = 0; i < N_IN; i++) write_coef(i, 16'h7FFF, 1);
    write_coef(N_IN, 16'h0000, 1);
    send_vec(fill(16'h7FFF), 0, 0, '0);
    wait_out(5);
    check("sat_or_wrap", out_data, SAT_EXP);

    // Backpressure.
    for (int i = 0; i < N_IN; i++) write_coef(i, 16'h0100, 1);
    out_ready = 1'b0;
    send_vec(fill(16'h0100), 0, 0, '0);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    hold = out_data;
    check("bp_value", hold, 16'h0500);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, hold);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_busy", busy, 0);
    wait_out(6);

    // Writes while busy are ignored; writes in IDLE take effect.
    send_vec(fill(16'h0100), 0, 0, '0);
    tick();
    write_coef(0, 16'h7FFF, 0);
    wait_out(7);
    check("busy_write_ignored", out_data, 16'h0500);
    write_coef(N_IN + 1, 16'h1234, 0);
    write_coef(0, 16'h7FFF, 1);
    repeat (3) tick();
    check("out_data_hold", out_data, 16'h0500);
    send_vec(fill(16'h0100), 0, 0, '0);
    wait_out(8);
    check("idle_write_used", out_data, W0_EXP);

    // Coefficient write in the same cycle as the transfer.
    send_vec(fill(16'h0100), 1, 1, 16'h0200);
    wait_out(9);
    check("same_cycle_write", out_data, SAME_EXP);

    // Reset in the middle of MAC.
    send_vec(fill(16'h0100), 0, 0, '0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_shadow();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    repeat (12) tick();
    check("midrst_no_result", n_out, 9);
    send_vec(fill(16'h0100), 0, 0, '0);
    wait_out(10);
    check("weights_cleared", out_data, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 Parameter N_IN, default 5, number of neuron inputs (1..64).
REQ-002 Parameter DW, default 16, two's-complement width of inputs, weights, bias and output.
REQ-003 Parameter FRAC, default 8, fractional bits of the fixed-point format (0..DW-2).
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input vector valid.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 in_data  input  N_IN*DW  packed signed inputs; element i at bits [i*DW +: DW].
REQ-009 w_we  input  1  coefficient write strobe.
REQ-010 w_addr  input  clog2(N_IN+1)  0..N_IN-1 select weight i; N_IN selects bias.
REQ-011 w_data  input  DW  signed coefficient value.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_data  output  DW  ReLU activation, unsigned-valued, MSB always 0.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, MAC, BIAS, OUT.
REQ-017 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both high.
REQ-018 On transfer, the block SHALL register in_data, clear the accumulator, set index 0, and enter MAC.
REQ-019 MAC SHALL add in[idx]*w[idx] (full 2*DW signed product) to the accumulator, one term per cycle, for N_IN cycles, then enter BIAS.
REQ-020 Accumulator width SHALL be 2*DW+clog2(N_IN+1) bits; no overflow is possible.
REQ-021 BIAS SHALL add bias sign-extended and left-shifted by FRAC, arithmetic-shift the sum right by FRAC (truncation toward minus infinity), force negative results to 0, and enter OUT.
REQ-022 In OUT, out_valid SHALL be 1 and out_data stable until out_ready is high; that cycle returns the FSM to IDLE.
REQ-023 Latency: transfer at cycle t SHALL give out_valid at cycle t+N_IN+2; throughput is one vector per N_IN+3 cycles with out_ready held high.
REQ-024 A w_we write in IDLE SHALL update the addressed coefficient on the next edge; writes while busy SHALL be ignored.
REQ-025 A w_we write and an input transfer in the same IDLE cycle SHALL both take effect; the new coefficient SHALL be used by that vector.
REQ-026 Writes with w_addr greater than N_IN SHALL be ignored.
REQ-027 out_data SHALL hold its last value outside OUT; out_valid SHALL be 0 outside OUT.

Reset
REQ-028 Reset SHALL force IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, and clear the accumulator, index, all weights and the bias.
REQ-029 Reset asserted in any state, including mid-MAC or OUT, SHALL discard the vector in progress with no out_valid pulse.

Configuration
REQ-030 With NEURON_SAT_EN defined, a non-negative result above 2^(DW-1)-1 SHALL clamp to 2^(DW-1)-1.
REQ-031 Without NEURON_SAT_EN, out_data SHALL be the low DW-1 bits of the non-negative result, with MSB 0 (wrap).

Structure
REQ-032 Package neuron_pkg SHALL hold the FSM state enum and the accumulator-width function.
REQ-033 Sub-module neuron_act SHALL implement the combinational shift, ReLU and saturate/wrap path.

Verification (N_IN=5, DW=16, FRAC=8)
REQ-034 Basic: all weights 0x0100, bias 0, inputs 0x0100 -> out_data 0x0500, out_valid at t+7.
REQ-035 ReLU: same as REQ-034 with bias 0xF000 -> out_data 0x0000.
REQ-036 Saturation: weights and inputs 0x7FFF -> 0x7FFF with NEURON_SAT_EN; without it, low 15 bits of the shifted sum with MSB 0.
REQ-037 Backpressure: out_ready low for 5 cycles -> out_valid, out_data stable and in_ready 0 throughout; back to IDLE the cycle after out_ready rises.
REQ-038 Coefficient protection: write w[0]=0x7FFF while busy -> result unchanged from REQ-034; same write in IDLE -> changes the next result.
REQ-039 Reset at MAC cycle 3 -> no out_valid, in_ready=1 the next cycle, weights read back 0 (next result 0x0000).
